// File: rtl/bus_slave_mem_if.sv
// simpleBUS slave-side byte channel: request from the master-select mux path and
// the responder's acknowledge/read-data return.
interface bus_slave_mem_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) ();

  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;
  logic              s_ack;
  logic              s_busy;

  modport master (
    output s_sel,
    output s_wr,
    output s_addr,
    output s_din,
    input  s_dout,
    input  s_ack,
    input  s_busy
  );

  modport slave (
    input  s_sel,
    input  s_wr,
    input  s_addr,
    input  s_din,
    output s_dout,
    output s_ack,
    output s_busy
  );

endinterface

// File: rtl/bus_slave_mem.sv
// simpleBUS byte-wide slave: decodes an address window, inserts programmable wait
// states, then writes/reads a small register file and returns a one-cycle ack.
module bus_slave_mem #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       MEM_DEPTH   = 32,
  parameter int unsigned       WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  bus_slave_mem_if.slave bus
);

  localparam int unsigned     IdxW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]      WaitLd = 4'(WAIT_CYCLES);
  localparam bit              NoWait = (WAIT_CYCLES == 0);
  // Window bounds carry one extra bit so BASE_ADDR+MEM_DEPTH never wraps.
  localparam logic [ADDR_W:0] WinLo  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WinHi  = WinLo + MEM_DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] din_q;
  logic              ack_q;
  logic              busy_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_W:0]   addr_ext;
  logic              hit;
  logic [IdxW-1:0]   req_idx;
  logic              op_wr;
  logic [IdxW-1:0]   op_idx;
  logic [DATA_W-1:0] op_din;
  logic              enter_ack;

  assign addr_ext = {1'b0, bus.s_addr};
  assign hit      = bus.s_sel && (addr_ext >= WinLo) && (addr_ext < WinHi);
  assign req_idx  = IdxW'(bus.s_addr - BASE_ADDR);

  // With no wait states the op commits on the accepting edge, straight from the bus.
  always_comb begin
    op_wr  = wr_q;
    op_idx = idx_q;
    op_din = din_q;
    if (state_q == StIdle) begin
      op_wr  = bus.s_wr;
      op_idx = req_idx;
      op_din = bus.s_din;
    end
  end

  assign enter_ack = ((state_q == StIdle) && hit && NoWait) ||
                     ((state_q == StWait) && (cnt_q == 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      din_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ack_q <= 1'b0;
      if (enter_ack) begin
        ack_q <= 1'b1;
        if (op_wr) begin
          mem_q[op_idx] <= op_din;
        end else begin
          dout_q <= mem_q[op_idx];
        end
      end

      case (state_q)
        StIdle: begin
          if (hit) begin
            wr_q    <= bus.s_wr;
            idx_q   <= req_idx;
            din_q   <= bus.s_din;
            cnt_q   <= WaitLd;
            busy_q  <= 1'b1;
            state_q <= NoWait ? StAck : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StAck;
          end
        end
        StAck: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.s_ack  = ack_q;
  assign bus.s_busy = busy_q;
  assign bus.s_dout = dout_q;

endmodule
